// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA timing generator: XGA defaults and a
// 640x480 set, plus a helper for the per-axis period.
package vga_timing_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int axis_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis.sv
// One timing axis: wrapping position counter with registered blank/sync
// levels derived from the next count, so flags always match the count.
module vga_axis
  import vga_timing_pkg::*;
#(
  parameter int CW       = 11,
  parameter int N_ACTIVE = XGA_H_ACTIVE,
  parameter int N_FP     = XGA_H_FP,
  parameter int N_SYNC   = XGA_H_SYNC,
  parameter int N_BP     = XGA_H_BP,
  parameter bit POL      = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv_i,
  output logic [CW-1:0] cnt_o,
  output logic          blnk_o,
  output logic          sync_o,
  output logic          wrap_o
);

  localparam logic [CW-1:0] LAST    = CW'(axis_total(N_ACTIVE, N_FP, N_SYNC, N_BP) - 1);
  localparam logic [CW-1:0] ACT     = CW'(N_ACTIVE);
  localparam logic [CW-1:0] SYNC_LO = CW'(N_ACTIVE + N_FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(N_ACTIVE + N_FP + N_SYNC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          blnk_q, blnk_d;
  logic          sync_q, sync_d;

  assign wrap_o = adv_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    blnk_d = (cnt_d >= ACT);
    sync_d = (cnt_d >= SYNC_LO && cnt_d < SYNC_HI) ? POL : ~POL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign blnk_o = blnk_q;
  assign sync_o = sync_q;

endmodule

// File: rtl/vga_timing_param.sv
// Parameterised raster timing generator: horizontal axis advances on pix_en,
// vertical axis advances on the horizontal wrap; start pulses are registered.
module vga_timing_param
  import vga_timing_pkg::*;
#(
  parameter int CW       = 11,
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW) ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("vga_timing_param: timing does not fit CW bits or has a zero field");
  end

  logic h_wrap, v_wrap;
  logic line_start_q, frame_start_q;

  vga_axis #(
    .CW(CW), .N_ACTIVE(H_ACTIVE), .N_FP(H_FP), .N_SYNC(H_SYNC), .N_BP(H_BP), .POL(HS_POL)
  ) u_h (
    .clk(clk), .rst(rst), .adv_i(pix_en),
    .cnt_o(hcount), .blnk_o(hblnk), .sync_o(hsync), .wrap_o(h_wrap)
  );

  vga_axis #(
    .CW(CW), .N_ACTIVE(V_ACTIVE), .N_FP(V_FP), .N_SYNC(V_SYNC), .N_BP(V_BP), .POL(VS_POL)
  ) u_v (
    .clk(clk), .rst(rst), .adv_i(h_wrap),
    .cnt_o(vcount), .blnk_o(vblnk), .sync_o(vsync), .wrap_o(v_wrap)
  );

  // Pulses land in the same cycle the counters show the new position.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Randomised and directed checks of vga_timing_param against a frame-position
// model (a single pixel index modulo the frame size).
module tb_vga_timing_param;

  localparam int CW = 4;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic [CW-1:0] hcount, vcount;
  logic hsync, vsync, hblnk, vblnk, line_start, frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int  p      = 0;
  bit  m_ls   = 0;
  bit  m_fs   = 0;
  bit  m_rst  = 1;

  always #5 clk = ~clk;

  vga_timing_param #(
    .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .line_start(line_start), .frame_start(frame_start)
  );

  function automatic int eh(); return p % HT; endfunction
  function automatic int ev(); return p / HT; endfunction
  function automatic bit e_hsync(); return !(eh() == 10 || eh() == 11); endfunction
  function automatic bit e_vsync(); return !(ev() == 5); endfunction
  function automatic bit e_hblnk(); return !m_rst && eh() >= 8; endfunction
  function automatic bit e_vblnk(); return !m_rst && ev() >= 4; endfunction

  // Drive one clock with the given inputs, advance the model, sample at +1.
  task automatic tick(input bit r, input bit en);
    rst = r;
    pix_en = en;
    @(posedge clk);
    if (r) begin
      p = 0; m_ls = 0; m_fs = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (en) begin
        p = (p + 1) % FRAME;
        m_ls = (eh() == 0);
        m_fs = (p == 0);
      end else begin
        m_ls = 0; m_fs = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    n_tests++;
    if (hcount !== 0 || vcount !== 0 || hblnk !== 0 || vblnk !== 0 || hsync !== 1 ||
        vsync !== 1 || line_start !== 0 || frame_start !== 0) begin
      n_fail++;
      $display("FAIL reset: h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b, want 0 0 0 0 1 1 0 0",
               hcount, vcount, hblnk, vblnk, hsync, vsync, line_start, frame_start);
    end
  endtask

  task automatic test_hsweep();
    tick(1'b1, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      tick(1'b0, 1'b1);
      n_tests++;
      if (hcount !== CW'(c % HT) || hsync !== e_hsync() || hblnk !== e_hblnk() ||
          line_start !== (c % HT == 0)) begin
        n_fail++;
        $display("FAIL hsweep c=%0d: h=%0d hs=%b hb=%b ls=%b, want h=%0d hs=%b hb=%b ls=%b",
                 c, hcount, hsync, hblnk, line_start, c % HT, e_hsync(), e_hblnk(), c % HT == 0);
      end
    end
  endtask

  task automatic test_frame();
    int fs_cnt, fs_at, vs_low;
    fs_cnt = 0; fs_at = -1; vs_low = 0;
    tick(1'b1, 1'b0);
    for (int c = 1; c <= FRAME; c++) begin
      tick(1'b0, 1'b1);
      if (frame_start) begin fs_cnt++; fs_at = c; end
      if (!vsync) vs_low++;
      n_tests++;
      if (vcount !== CW'(ev()) || vblnk !== e_vblnk() || vsync !== e_vsync()) begin
        n_fail++;
        $display("FAIL frame c=%0d: v=%0d vb=%b vs=%b, want v=%0d vb=%b vs=%b",
                 c, vcount, vblnk, vsync, ev(), e_vblnk(), e_vsync());
      end
    end
    n_tests++;
    if (fs_cnt != 1 || fs_at != FRAME || vs_low != HT) begin
      n_fail++;
      $display("FAIL frame_summary: fs_cnt=%0d at=%0d vs_low=%0d, want 1 at %0d vs_low %0d",
               fs_cnt, fs_at, vs_low, FRAME, HT);
    end
  endtask

  task automatic test_toggle();
    int first_fs, second_fs, hprev;
    bit en;
    first_fs = -1; second_fs = -1;
    tick(1'b1, 1'b0);
    hprev = 0;
    for (int c = 1; c <= 2 * 2 * FRAME + 4; c++) begin
      en = c[0];
      tick(1'b0, en);
      if (frame_start) begin
        if (first_fs < 0) first_fs = c;
        else if (second_fs < 0) second_fs = c;
      end
      n_tests++;
      if (hcount !== CW'(eh()) || (!en && (line_start || frame_start)) ||
          line_start !== m_ls || (!en && hcount !== CW'(hprev))) begin
        n_fail++;
        $display("FAIL toggle c=%0d en=%b: h=%0d ls=%b fs=%b, want h=%0d ls=%b",
                 c, en, hcount, line_start, frame_start, eh(), m_ls);
      end
      hprev = hcount;
    end
    n_tests++;
    if (first_fs != 2 * FRAME - 1 || second_fs - first_fs != 2 * FRAME) begin
      n_fail++;
      $display("FAIL toggle_frame_len: first=%0d gap=%0d, want first=%0d gap=%0d",
               first_fs, second_fs - first_fs, 2 * FRAME - 1, 2 * FRAME);
    end
  endtask

  task automatic test_mid_reset();
    int fs_at;
    fs_at = -1;
    tick(1'b1, 1'b0);
    for (int c = 0; c < 3 * HT + 9; c++) tick(1'b0, 1'b1);
    n_tests++;
    if (hcount !== 9 || vcount !== 3) begin
      n_fail++;
      $display("FAIL midrst_pos: h=%0d v=%0d, want 9 3", hcount, vcount);
    end
    tick(1'b1, 1'b1);
    n_tests++;
    if (hcount !== 0 || vcount !== 0 || hblnk !== 0 || vblnk !== 0 || hsync !== 1 ||
        vsync !== 1 || line_start !== 0 || frame_start !== 0) begin
      n_fail++;
      $display("FAIL midrst_vals: h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b ls=%b fs=%b",
               hcount, vcount, hblnk, vblnk, hsync, vsync, line_start, frame_start);
    end
    for (int c = 1; c <= FRAME; c++) begin
      tick(1'b0, 1'b1);
      if (frame_start && fs_at < 0) fs_at = c;
    end
    n_tests++;
    if (fs_at != FRAME) begin
      n_fail++;
      $display("FAIL midrst_fs: first frame_start at %0d, want %0d", fs_at, FRAME);
    end
  endtask

  task automatic test_random();
    bit r, en;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 3) != 0);
      tick(r, en);
      n_tests++;
      if (hcount !== CW'(eh()) || vcount !== CW'(ev()) || hsync !== e_hsync() ||
          vsync !== e_vsync() || hblnk !== e_hblnk() || vblnk !== e_vblnk() ||
          line_start !== m_ls || frame_start !== m_fs) begin
        n_fail++;
        $display("FAIL random c=%0d: h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b, want %0d %0d %b %b %b %b %b %b",
                 c, hcount, vcount, hsync, vsync, hblnk, vblnk, line_start, frame_start,
                 eh(), ev(), e_hsync(), e_vsync(), e_hblnk(), e_vblnk(), m_ls, m_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsweep();
    test_frame();
    test_toggle();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
VGA_TIMING_PARAM -- requirements
Module: vga_timing_param

Interface
REQ-001 The block SHALL have parameter CW, default 11, counter width in bits.
REQ-002 The block SHALL have parameters H_ACTIVE=1024, H_FP=24, H_SYNC=136, H_BP=160, giving horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_ACTIVE=768, V_FP=3, V_SYNC=6, V_BP=29, giving vertical timing in lines.
REQ-004 The block SHALL have parameters HS_POL=0 and VS_POL=0, the sync level while the pulse is asserted (0 = active-low).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have the following ports, one per line:
- clk  input  1  pixel-domain clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- pix_en  input  1  pixel advance enable, clock-enable for divided pixel rates
- hcount  output  CW  horizontal position, 0 to H_TOTAL-1
- vcount  output  CW  vertical position, 0 to V_TOTAL-1
- hsync  output  1  horizontal sync at HS_POL level during the sync window
- vsync  output  1  vertical sync at VS_POL level during the sync window
- hblnk  output  1  high while hcount >= H_ACTIVE
- vblnk  output  1  high while vcount >= V_ACTIVE
- line_start  output  1  one-cycle pulse on entry to hcount=0
- frame_start  output  1  one-cycle pulse on entry to hcount=0, vcount=0

Function
REQ-007 The block SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; elaboration SHALL fail if either exceeds 2^CW or any parameter is 0.
REQ-008 All outputs SHALL be registered and mutually coherent: the flags presented in a cycle SHALL describe the hcount/vcount presented in that same cycle.
REQ-009 When pix_en=1, hcount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL advance.
REQ-010 vcount SHALL advance only on an hcount wrap; at V_TOTAL-1 it SHALL wrap to 0.
REQ-011 When pix_en=0, all counters and levels SHALL hold, and line_start and frame_start SHALL be 0.
REQ-012 hsync SHALL equal HS_POL for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise; vsync SHALL follow the same rule on vcount with V parameters and VS_POL.
REQ-013 vsync and vblnk SHALL change only on the same cycle that vcount changes, and never mid-line.
REQ-014 line_start SHALL be 1 for exactly one clk cycle when hcount transitions to 0; frame_start SHALL be 1 only when that transition coincides with vcount transitioning to 0.
REQ-015 Latency SHALL be zero cycles from counter to flags (coherent per REQ-008); the first advance SHALL occur on the first clk edge with pix_en=1 after rst deasserts.

Reset
REQ-016 While rst=1: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
REQ-017 Reset exit SHALL NOT generate line_start or frame_start; the first frame_start SHALL occur at the first full-frame wrap.
REQ-018 Reset asserted mid-frame SHALL take priority over pix_en and return all outputs to REQ-016 values on the next edge.

Structure
REQ-019 Default XGA timing constants, and a VGA 640x480 constant set (640/16/96/48, 480/10/2/33), SHALL reside in a shared package, vga_timing_pkg.
REQ-020 A single sub-module, vga_axis, SHALL implement one axis (count, blnk, sync, wrap) from an advance input. It SHALL be instantiated twice: horizontal with advance=pix_en, vertical with advance=horizontal wrap.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL=14), V 4/1/1/1 (V_TOTAL=7), CW=4, HS_POL=VS_POL=0.
REQ-021 Reset, then pix_en=1 constant -> hcount runs 0..13 then wraps to 0; hsync=0 exactly at hcount 10,11; hblnk=1 at hcount 8..13.
REQ-022 pix_en=1 constant for 98 cycles -> one frame_start at cycle 98; vsync=0 for vcount=5 (14 clk); vblnk=1 for vcount 4..6.
REQ-023 pix_en toggling 1,0,1,0 -> hcount advances on alternate cycles; line_start never asserted with pix_en=0; frame length 196 clk.
REQ-024 rst=1 asserted at hcount=9, vcount=3 -> next cycle all outputs at reset values; no frame_start until 98 advances later.
REQ-025 Elaborate with CW=3 and the bench parameters -> elaboration error (H_TOTAL=14 > 8).
